// File: rtl/watch_pkg.sv
// Shared definitions for the watch timekeeper.
//   mode_t      : FSM encodings, visible on the top-level mode port
//   HOURS_MAX   : last valid BCD hours value (23)
//   MINSEC_MAX  : last valid BCD minutes/seconds value (59)
//   bcd_inc()   : increment a two-digit BCD value, wrapping to 00 after max
package watch_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_t;

    localparam logic [7:0] HOURS_MAX  = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    // Works digit-wise, so the value never leaves legal BCD and no binary
    // conversion is needed anywhere.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
        if (val == max) begin
            return 8'h00;
        end
        if (val[3:0] == 4'd9) begin
            return {val[7:4] + 4'd1, 4'd0};
        end
        return {val[7:4], val[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/watch_debounce.sv
// Button conditioner: 2-flop synchronizer, counting debouncer, rising-edge
// press detector.
//   clk   : clock
//   rst   : synchronous active-high reset
//   raw   : asynchronous button input, active-high
//   level : debounced button level
//   press : one-cycle pulse in the first cycle the debounced level is 1
module watch_debounce #(
    parameter int DB_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // cnt counts consecutive cycles in which the synchronized input disagrees
    // with the accepted level; any agreeing cycle restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;     // only a 0->1 acceptance is an event
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/watch_timekeeper.sv
// 24-hour BCD watch with two-button time setting.
//   clk         : clock, all state changes on its rising edge
//   rst         : synchronous active-high reset
//   run_en      : prescaler enable
//   btn_mode    : raw mode button (RUN -> SET_HR -> SET_MIN -> RUN)
//   btn_inc     : raw increment button for the field being set
//   hours_bcd   : BCD hours 00-23
//   minutes_bcd : BCD minutes 00-59
//   seconds_bcd : BCD seconds 00-59
//   mode        : FSM state (0 RUN, 1 SET_HR, 2 SET_MIN)
//   sec_pulse   : one-cycle strobe at each prescaler wrap
//   blink       : blanking hint for the field being set
module watch_timekeeper
    import watch_pkg::*;
#(
    parameter int TICK_DIV  = 10000000,
    parameter int DB_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hours_bcd,
    output logic [7:0] minutes_bcd,
    output logic [7:0] seconds_bcd,
    output logic [1:0] mode,
    output logic       sec_pulse,
    output logic       blink
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    mode_t         state;
    mode_t         state_next;
    logic [PW-1:0] presc;
    logic          tick;
    logic          mode_level;
    logic          mode_press;
    logic          inc_level;
    logic          inc_press;
    logic          mode_ev;
    logic          inc_ev;
    logic          exit_set;

    watch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_mode),
        .level (mode_level),
        .press (mode_press)
    );

    watch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_inc),
        .level (inc_level),
        .press (inc_press)
    );

    // A press is only meaningful while its debounced level is high. When both
    // buttons fire together the mode step wins and the inc event is dropped.
    assign mode_ev  = mode_press & mode_level;
    assign inc_ev   = inc_press & inc_level & ~mode_ev;
    assign exit_set = mode_ev && (state == MODE_SET_MIN);

    // Time advances on the same edge that raises sec_pulse.
    assign tick = run_en && (presc == PRESC_LAST);

    assign mode = state;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MODE_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (mode_ev) begin
            case (state)
                MODE_RUN:     state_next = MODE_SET_HR;
                MODE_SET_HR:  state_next = MODE_SET_MIN;
                MODE_SET_MIN: state_next = MODE_RUN;
                default:      state_next = MODE_RUN;
            endcase
        end
    end

    // ---------------- prescaler ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= tick;
            if (exit_set) begin
                presc <= '0;        // leaving SET starts a fresh full second
            end else if (run_en) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
        end
    end

    // ---------------- time registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hours_bcd   <= 8'h00;
            minutes_bcd <= 8'h00;
            seconds_bcd <= 8'h00;
        end else begin
            case (state)
                MODE_RUN: begin
                    if (tick) begin
                        seconds_bcd <= bcd_inc(seconds_bcd, MINSEC_MAX);
                        if (seconds_bcd == MINSEC_MAX) begin
                            minutes_bcd <= bcd_inc(minutes_bcd, MINSEC_MAX);
                            if (minutes_bcd == MINSEC_MAX) begin
                                hours_bcd <= bcd_inc(hours_bcd, HOURS_MAX);
                            end
                        end
                    end
                end
                MODE_SET_HR: begin
                    if (inc_ev) begin
                        hours_bcd <= bcd_inc(hours_bcd, HOURS_MAX);
                    end
                end
                MODE_SET_MIN: begin
                    if (inc_ev) begin
                        minutes_bcd <= bcd_inc(minutes_bcd, MINSEC_MAX);
                    end
                    if (exit_set) begin
                        seconds_bcd <= 8'h00;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- blink ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            blink <= 1'b0;
        end else if (state_next == MODE_RUN) begin
            blink <= 1'b0;
        end else if (tick) begin
            blink <= ~blink;
        end
    end

endmodule

// File: tb/tb_watch_timekeeper.sv
module tb_watch_timekeeper;

    logic       clk;
    logic       rst;
    logic       run_en;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] hours_bcd;
    logic [7:0] minutes_bcd;
    logic [7:0] seconds_bcd;
    logic [1:0] mode;
    logic       sec_pulse;
    logic       blink;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] exp_q[$];

    typedef struct {
        logic       bm;
        logic       bi;
        int         hold;
        int         reps;
        logic [1:0] m;
        logic [7:0] h;
        logic [7:0] mi;
        logic [7:0] s;
        string      name;
    } vec_t;

    vec_t vecs[13];

    watch_timekeeper #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .run_en      (run_en),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .hours_bcd   (hours_bcd),
        .minutes_bcd (minutes_bcd),
        .seconds_bcd (seconds_bcd),
        .mode        (mode),
        .sec_pulse   (sec_pulse),
        .blink       (blink)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    // Hold raw button levels for 'hold' cycles, then release and let the
    // debouncer settle before the next action.
    task automatic press(input logic bm, input logic bi, input int hold);
        btn_mode = bm;
        btn_inc  = bi;
        repeat (hold) step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (8) step();
    endtask

    // Scoreboard drain: pop one expected time per observed sec_pulse.
    task automatic run_seconds(input int budget, input string tag);
        int          cyc;
        logic [23:0] e;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            step();
            cyc++;
            if (sec_pulse) begin
                e = exp_q.pop_front();
                check(tag, {hours_bcd, minutes_bcd, seconds_bcd}, e);
            end
        end
        check({tag, "_remaining"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- test ----------------
    initial begin
        int npulse;
        int pulses_off;

        // Starting point for the table: 00:01:03, RUN, run_en=0.
        vecs[0]  = '{1'b0, 1'b1, 10, 1,  2'd0, 8'h00, 8'h01, 8'h03, "inc_in_run"};
        vecs[1]  = '{1'b1, 1'b0, 10, 1,  2'd1, 8'h00, 8'h01, 8'h03, "to_set_hr"};
        vecs[2]  = '{1'b0, 1'b1, 2,  1,  2'd1, 8'h00, 8'h01, 8'h03, "hr_glitch"};
        vecs[3]  = '{1'b0, 1'b1, 10, 23, 2'd1, 8'h23, 8'h01, 8'h03, "hr_to_23"};
        vecs[4]  = '{1'b0, 1'b1, 10, 1,  2'd1, 8'h00, 8'h01, 8'h03, "hr_wrap"};
        vecs[5]  = '{1'b0, 1'b1, 10, 23, 2'd1, 8'h23, 8'h01, 8'h03, "hr_back_23"};
        vecs[6]  = '{1'b1, 1'b1, 10, 1,  2'd2, 8'h23, 8'h01, 8'h03, "coincident"};
        vecs[7]  = '{1'b0, 1'b1, 2,  1,  2'd2, 8'h23, 8'h01, 8'h03, "min_glitch"};
        vecs[8]  = '{1'b0, 1'b1, 10, 1,  2'd2, 8'h23, 8'h02, 8'h03, "min_inc1"};
        vecs[9]  = '{1'b0, 1'b1, 10, 57, 2'd2, 8'h23, 8'h59, 8'h03, "min_to_59"};
        vecs[10] = '{1'b0, 1'b1, 10, 1,  2'd2, 8'h23, 8'h00, 8'h03, "min_wrap"};
        vecs[11] = '{1'b0, 1'b1, 10, 59, 2'd2, 8'h23, 8'h59, 8'h03, "min_back_59"};
        vecs[12] = '{1'b1, 1'b0, 10, 1,  2'd0, 8'h23, 8'h59, 8'h00, "exit_run"};

        rst      = 1'b1;
        run_en   = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;

        // Reset
        repeat (2) step();
        check("rst_hours", hours_bcd, 8'h00);
        check("rst_minutes", minutes_bcd, 8'h00);
        check("rst_seconds", seconds_bcd, 8'h00);
        check("rst_mode", mode, 2'd0);
        check("rst_sec_pulse", sec_pulse, 1'b0);
        check("rst_blink", blink, 1'b0);

        // Counting: 240 cycles -> 60 pulses, one every 4th cycle
        rst    = 1'b0;
        run_en = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            exp_q.push_back({8'h00, to_bcd(k / 60), to_bcd(k % 60)});
        end
        npulse = 0;
        for (int cyc = 1; cyc <= 240; cyc++) begin
            step();
            if (sec_pulse) begin
                npulse++;
                check("pulse_cycle", cyc, 4 * npulse);
                if (exp_q.size() > 0) begin
                    check("count_time", {hours_bcd, minutes_bcd, seconds_bcd}, exp_q.pop_front());
                end
            end
        end
        check("count_pulses", npulse, 60);
        check("count_final", {hours_bcd, minutes_bcd, seconds_bcd}, 24'h000100);
        exp_q.delete();

        // Three more seconds, then freeze the prescaler
        exp_q.push_back(24'h000101);
        exp_q.push_back(24'h000102);
        exp_q.push_back(24'h000103);
        run_seconds(20, "run3");
        run_en = 1'b0;
        pulses_off = 0;
        repeat (20) begin
            step();
            if (sec_pulse) pulses_off++;
        end
        check("hold_no_pulse", pulses_off, 0);
        check("hold_time", {hours_bcd, minutes_bcd, seconds_bcd}, 24'h000103);

        // Table-driven button sequences: set 23:59 and return to RUN
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                press(vecs[i].bm, vecs[i].bi, vecs[i].hold);
            end
            check({vecs[i].name, "_mode"}, mode, vecs[i].m);
            check({vecs[i].name, "_hours"}, hours_bcd, vecs[i].h);
            check({vecs[i].name, "_minutes"}, minutes_bcd, vecs[i].mi);
            check({vecs[i].name, "_seconds"}, seconds_bcd, vecs[i].s);
        end

        // Rollover: 60 s from 23:59:00
        run_en = 1'b1;
        for (int k = 1; k <= 59; k++) begin
            exp_q.push_back({8'h23, 8'h59, to_bcd(k)});
        end
        exp_q.push_back(24'h000000);
        run_seconds(260, "rollover");
        check("rollover_final", {hours_bcd, minutes_bcd, seconds_bcd}, 24'h000000);

        // Blink in SET_MIN, then mid-operation reset
        run_en = 1'b0;
        press(1'b1, 1'b0, 10);
        check("set_hr_blink", blink, 1'b0);
        press(1'b0, 1'b1, 10);
        check("set_hr_inc", hours_bcd, 8'h01);
        press(1'b1, 1'b0, 10);
        press(1'b0, 1'b1, 10);
        check("set_min_inc", minutes_bcd, 8'h01);
        run_en = 1'b1;
        begin
            int cyc;
            cyc = 0;
            while (!sec_pulse && cyc < 12) begin
                step();
                cyc++;
            end
            check("set_pulse_seen", sec_pulse, 1'b1);
        end
        check("set_blink_on", blink, 1'b1);
        check("set_mode", mode, 2'd2);
        check("set_seconds_frozen", seconds_bcd, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_mode", mode, 2'd0);
        check("mid_rst_blink", blink, 1'b0);
        check("mid_rst_time", {hours_bcd, minutes_bcd, seconds_bcd}, 24'h000000);
        check("mid_rst_pulse", sec_pulse, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
